wb_copy_master: RTL

- Wishbone initiator that copies LEN 32-bit words from a source address to a destination address, one read then one write per word.
- This is the bus-master counterpart to the on-chip Wishbone slaves (BRAM, peripherals). It lets software or boot logic move images between memories without the CPU.
- It is built for the non-pipelined slave style used across the SoC. Those slaves hold ack while cyc&stb stays high, so every transfer ends with a mandatory idle (gap) cycle.

---
 rtl/wb_copy_master_pkg.sv | 19 +
 rtl/wb_copy_master_timeout.sv | 37 +++
 rtl/wb_copy_master.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/wb_copy_master_pkg.sv
// Shared types and constants for the Wishbone copy master.
package wb_copy_master_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RD_GAP,
        WR,
        WR_GAP,
        FINISH
    } state_e;

    localparam int WB_WORD_BYTES = 4;

    function automatic int tmo_cnt_width(input int timeout_cycles);
        return $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/wb_copy_master_timeout.sv
// Bus-request watchdog: counts cycles spent waiting for a slave termination.
import wb_copy_master_pkg::*;

module wb_timeout_counter #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = tmo_cnt_width(TIMEOUT_CYCLES)
) (
    input  logic sys_clk,
    input  logic sys_rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Fires in the last waiting cycle so the request sees exactly TIMEOUT_CYCLES strobes.
    assign expired = enable && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && !expired) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/wb_copy_master.sv
// Wishbone initiator copying len words from src_addr to dst_addr, one read then one
// write per word, with an idle cycle after every transfer for held-ack slaves.
import wb_copy_master_pkg::*;

module wb_copy_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int LEN_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] src_addr,
    input  logic [ADDR_WIDTH-1:0] dst_addr,
    input  logic [LEN_WIDTH-1:0]  len,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_WIDTH-1:0]  words_left,
    output logic                  wb_cyc,
    output logic                  wb_stb,
    output logic                  wb_we,
    output logic [ADDR_WIDTH-1:0] wb_adr,
    output logic [31:0]           wb_mosi,
    input  logic [31:0]           wb_miso,
    input  logic                  wb_ack,
    input  logic                  wb_err
);

    localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(WB_WORD_BYTES);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [31:0]           data_q, data_d;
    logic [LEN_WIDTH-1:0]  words_left_q, words_left_d;
    logic                  error_q, error_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  cyc_q, cyc_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [31:0]           mosi_q, mosi_d;
    logic                  in_req;
    logic                  tmo_expired;

    assign in_req = (state_q == RD) || (state_q == WR);

    wb_timeout_counter #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .clear   (!in_req),
        .enable  (in_req),
        .expired (tmo_expired)
    );

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        dst_d        = dst_q;
        data_d       = data_q;
        words_left_d = words_left_q;
        error_d      = error_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    src_d        = {src_addr[ADDR_WIDTH-1:2], 2'b00};
                    dst_d        = {dst_addr[ADDR_WIDTH-1:2], 2'b00};
                    words_left_d = len;
                    error_d      = 1'b0;
                    state_d      = (len != '0) ? RD : FINISH;
                end
            end
            RD: begin
                if (wb_err) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else if (wb_ack) begin
                    data_d  = wb_miso;
                    src_d   = src_q + STEP;
                    state_d = RD_GAP;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            RD_GAP: state_d = WR;
            WR: begin
                if (wb_err) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end else if (wb_ack) begin
                    dst_d        = dst_q + STEP;
                    words_left_d = words_left_q - LEN_WIDTH'(1);
                    state_d      = WR_GAP;
                end else if (tmo_expired) begin
                    error_d = 1'b1;
                    state_d = FINISH;
                end
            end
            WR_GAP: state_d = (words_left_q == '0) ? FINISH : RD;
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bus outputs are registered, so derive them from the upcoming state.
        busy_d = (state_d != IDLE);
        done_d = (state_q == FINISH);
        cyc_d  = (state_d == RD) || (state_d == WR);
        we_d   = (state_d == WR);
        adr_d  = adr_q;
        mosi_d = mosi_q;
        if (state_d == RD) begin
            adr_d = src_d;
        end else if (state_d == WR) begin
            adr_d  = dst_d;
            mosi_d = data_d;
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_q      <= IDLE;
            src_q        <= '0;
            dst_q        <= '0;
            data_q       <= '0;
            words_left_q <= '0;
            error_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            cyc_q        <= 1'b0;
            we_q         <= 1'b0;
            adr_q        <= '0;
            mosi_q       <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            dst_q        <= dst_d;
            data_q       <= data_d;
            words_left_q <= words_left_d;
            error_q      <= error_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            cyc_q        <= cyc_d;
            we_q         <= we_d;
            adr_q        <= adr_d;
            mosi_q       <= mosi_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign words_left = words_left_q;
    assign wb_cyc     = cyc_q;
    assign wb_stb     = cyc_q;
    assign wb_we      = we_q;
    assign wb_adr     = adr_q;
    assign wb_mosi    = mosi_q;

endmodule
